dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address bits (RAM depth 2**ADDR_WIDTH 32-bit words, 256 words = 1 KiB by default).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per access, legal range 0..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  initiator request strobe; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  32  byte address of access.
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte enables; be[i] selects wdata[8i+7:8i].
REQ-010 rdata  output  32  read data; valid only while ready=1, else 0.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 err  output  1  error flag; valid only while ready=1, else 0.
REQ-013 gpio_out  output  32  memory-mapped output register (see Configuration).

Function
REQ-014 FSM states IDLE, WAIT, RESP; IDLE after reset.
REQ-015 IDLE, req=1 at edge k: latch we/addr/wdata/be; go to RESP if WAIT_CYCLES=0, else WAIT with counter loaded to WAIT_CYCLES-1.
REQ-016 WAIT: counter decrements each edge; at counter=0, go to RESP; req/inputs ignored throughout.
REQ-017 RESP entered at edge k+WAIT_CYCLES; ready=1 for exactly the following cycle, then unconditionally IDLE.
REQ-018 req high during RESP ignored; next request is accepted no earlier than the edge after leaving RESP (throughput one access per WAIT_CYCLES+2 cycles).
REQ-019 Misaligned (addr[1:0]!=0) or out-of-range (addr[31:ADDR_WIDTH+2]!=0, excluding MMIO addresses when enabled): err=1, rdata=0, no state modified.
REQ-020 Valid write: only enabled bytes of word addr[ADDR_WIDTH+1:2] updated, committed at the edge entering RESP; rdata=0 for writes.
REQ-021 Valid read: rdata = full stored word captured at edge entering RESP; be ignored for reads.
REQ-022 RAM array not reset; reads of never-written words return undefined data.
REQ-023 Write immediately followed by read of same word returns the newly written data.

Reset
REQ-024 reset=0 forces IDLE, ready=0, err=0, rdata=0, gpio_out=0, counters=0, asynchronously.
REQ-025 Reset during WAIT discards the pending access; RAM untouched; no ready pulse follows.
REQ-026 First request accepted at the first rising edge with reset=1.

Configuration
REQ-027 Macro DMEM_RESPONDER_MMIO_EN compiles in MMIO region.
REQ-028 With macro: 0xFFFF_FF00 = gpio register (R/W, byte-enabled, drives gpio_out); 0xFFFF_FF04 = read-only free-running 32-bit cycle counter (reset 0, wraps 0xFFFF_FFFF->0, writes ignored, err=0).
REQ-029 Without macro: both addresses are out-of-range (err=1); gpio_out tied to 0; no counter logic.

Verification (WAIT_CYCLES=2, ADDR_WIDTH=8)
REQ-030 Write addr=0x10, wdata=0xDEADBEEF, be=4'hF, req at edge k -> ready=1 in cycle after edge k+2, err=0; then read 0x10 -> rdata=0xDEADBEEF.
REQ-031 Write 0x10 wdata=0x11223344 be=4'b0101 over 0xDEADBEEF -> read 0x10 returns 0xDE22BE44.
REQ-032 Read addr=0x12 -> ready pulse, err=1, rdata=0; write addr=0x400 -> err=1, RAM word 0 unchanged.
REQ-033 Assert reset=0 one cycle after accepting write 0x20 = 0xCAFEF00D -> no ready pulse; subsequent read 0x20 shows old contents; req held high continuously -> ready every 4 cycles.
REQ-034 With DMEM_RESPONDER_MMIO_EN: write 0xFFFF_FF00 = 0x000000A5 be=4'h1 -> gpio_out=0x000000A5 after RESP edge; two reads of 0xFFFF_FF04 spaced 4 cycles apart differ by 4. Without macro: same write -> err=1, gpio_out=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle.
// Initiator drives the request side; responder drives the completion side.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder with byte-enabled 32-bit RAM.
// Optional MMIO region (gpio + cycle counter) under DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus,
    output logic [31:0]        gpio_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit         NOWAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WLOAD  =
        NOWAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic        in_idle;
    logic        go_resp;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        misal, oor, mmio_hit, bad;
    logic        ram_we;
    logic [ADDR_WIDTH-1:0] idx;

    // With zero wait states the access completes on its accept edge,
    // so the live bus fields are used instead of the latched copies.
    assign in_idle   = (state_q == S_IDLE);
    assign cur_we    = in_idle ? bus.we    : we_q;
    assign cur_addr  = in_idle ? bus.addr  : addr_q;
    assign cur_wdata = in_idle ? bus.wdata : wdata_q;
    assign cur_be    = in_idle ? bus.be    : be_q;

    assign go_resp = (in_idle && bus.req && NOWAIT)
                  || (state_q == S_WAIT && cnt_q == 4'd0);

    assign idx   = cur_addr[ADDR_WIDTH+1:2];
    assign misal = (cur_addr[1:0] != 2'b00);
    assign oor   = (cur_addr[31:ADDR_WIDTH+2] != '0);
    assign bad   = misal | (oor & ~mmio_hit);
    assign ram_we = go_resp & cur_we & ~bad & ~mmio_hit;

`ifdef DMEM_RESPONDER_MMIO_EN
    logic        hit_gpio, hit_cyc;
    logic [31:0] gpio_q, cyc_q;

    assign hit_gpio = (cur_addr == 32'hFFFF_FF00);
    assign hit_cyc  = (cur_addr == 32'hFFFF_FF04);
    assign mmio_hit = hit_gpio | hit_cyc;
    assign gpio_out = gpio_q;

    // Byte-enabled gpio register; counter free-runs and ignores writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q <= '0;
            cyc_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (go_resp && cur_we && hit_gpio) begin
                for (int b = 0; b < 4; b++) begin
                    if (cur_be[b]) gpio_q[8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    assign mmio_hit = 1'b0;
    assign gpio_out = '0;
`endif

    // Response data: stored word for good reads, zero otherwise.
    always_comb begin
        rdata_d = '0;
        err_d   = bad;
        if (!cur_we && !bad) begin
`ifdef DMEM_RESPONDER_MMIO_EN
            if (hit_gpio)     rdata_d = gpio_q;
            else if (hit_cyc) rdata_d = cyc_q;
            else              rdata_d = mem_q[idx];
`else
            rdata_d = mem_q[idx];
`endif
        end
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = NOWAIT ? S_RESP : S_WAIT;
                    cnt_d   = WLOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, request latch and one-cycle response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                be_q    <= bus.be;
            end
            rdata_q <= go_resp ? rdata_d : '0;
            err_q   <= go_resp ? err_d   : 1'b0;
        end
    end

    // RAM array, byte-enabled write committed on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign bus.ready = (state_q == S_RESP);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Default parameters (ADDR_WIDTH=8, WAIT_CYCLES=2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_out;

    int checks = 0;
    int errors = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_WIDTH (8),
        .WAIT_CYCLES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ready pulse.
    task automatic access(input  logic        w,
                          input  logic [31:0] a,
                          input  logic [31:0] d,
                          input  logic [3:0]  b,
                          output logic [31:0] rd,
                          output logic        e);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        @(posedge clk);
        #1;
        bus.req   = 1'b0;
        bus.we    = ~w;
        bus.addr  = 32'h0000_0003;
        bus.wdata = 32'h0BAD_0BAD;
        bus.be    = 4'h0;
        @(negedge clk);
        chk("wait1_ready", {31'b0, bus.ready}, 32'd0);
        @(negedge clk);
        chk("wait2_ready", {31'b0, bus.ready}, 32'd0);
        @(negedge clk);
        chk("resp_ready", {31'b0, bus.ready}, 32'd1);
        rd = bus.rdata;
        e  = bus.err;
        @(negedge clk);
        chk("post_ready", {31'b0, bus.ready}, 32'd0);
        chk("post_rdata", bus.rdata, 32'd0);
    endtask

    logic [31:0] rd, c1, c2;
    logic        e;

    initial begin
        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        #12;
        chk("rst_ready", {31'b0, bus.ready}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_gpio", gpio_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Full write then read back, be ignored on read.
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e);
        chk("wr10_err", {31'b0, e}, 32'd0);
        chk("wr10_rdata", rd, 32'd0);
        access(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("rd10_err", {31'b0, e}, 32'd0);
        chk("rd10_data", rd, 32'hDEAD_BEEF);

        // Partial byte write.
        access(1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, e);
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, e);
        chk("rd10_merge", rd, 32'hDE22_BE44);

        // Top word boundary.
        access(1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, rd, e);
        chk("wr3fc_err", {31'b0, e}, 32'd0);
        access(1'b0, 32'h3FC, 32'h0, 4'hF, rd, e);
        chk("rd3fc_data", rd, 32'hA5A5_5A5A);

        // Misaligned and out-of-range accesses.
        access(1'b1, 32'h0, 32'h0102_0304, 4'hF, rd, e);
        access(1'b0, 32'h12, 32'h0, 4'hF, rd, e);
        chk("rd12_err", {31'b0, e}, 32'd1);
        chk("rd12_rdata", rd, 32'd0);
        access(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, e);
        chk("wr400_err", {31'b0, e}, 32'd1);
        access(1'b1, 32'h13, 32'hFFFF_FFFF, 4'hF, rd, e);
        chk("wr13_err", {31'b0, e}, 32'd1);
        access(1'b0, 32'h0, 32'h0, 4'hF, rd, e);
        chk("rd0_kept", rd, 32'h0102_0304);
        access(1'b0, 32'h10, 32'h0, 4'hF, rd, e);
        chk("rd10_kept", rd, 32'hDE22_BE44);

        // Reset during WAIT discards the pending write.
        access(1'b1, 32'h20, 32'h55AA_55AA, 4'hF, rd, e);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h20;
        bus.wdata = 32'hCAFE_F00D;
        bus.be    = 4'hF;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_ready", {31'b0, bus.ready}, 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_noresp", {31'b0, bus.ready}, 32'd0);
        end
        access(1'b0, 32'h20, 32'h0, 4'hF, rd, e);
        chk("rd20_old", rd, 32'h55AA_55AA);

        // Continuous request: one completion every 4 cycles.
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h0;
        bus.be   = 4'hF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("held_ready", {31'b0, bus.ready}, {31'b0, (i % 4) == 2});
            if ((i % 4) == 2) chk("held_rdata", bus.rdata, 32'h0102_0304);
        end
        bus.req = 1'b0;
        @(negedge clk);
        chk("held_idle", {31'b0, bus.ready}, 32'd0);

`ifdef DMEM_RESPONDER_MMIO_EN
        access(1'b1, 32'hFFFF_FF00, 32'h0000_00A5, 4'h1, rd, e);
        chk("gpio_wr_err", {31'b0, e}, 32'd0);
        chk("gpio_out", gpio_out, 32'h0000_00A5);
        access(1'b0, 32'hFFFF_FF00, 32'h0, 4'hF, rd, e);
        chk("gpio_rd", rd, 32'h0000_00A5);
        access(1'b0, 32'hFFFF_FF04, 32'h0, 4'hF, rd, e);
        c1 = rd;
        chk("cyc_err", {31'b0, e}, 32'd0);
        access(1'b0, 32'hFFFF_FF04, 32'h0, 4'hF, rd, e);
        c2 = rd;
        chk("cyc_delta", c2 - c1, 32'd4);
        access(1'b1, 32'hFFFF_FF04, 32'h0, 4'hF, rd, e);
        chk("cyc_wr_err", {31'b0, e}, 32'd0);
`else
        access(1'b1, 32'hFFFF_FF00, 32'h0000_00A5, 4'h1, rd, e);
        chk("gpio_wr_err", {31'b0, e}, 32'd1);
        chk("gpio_out", gpio_out, 32'd0);
        access(1'b0, 32'hFFFF_FF04, 32'h0, 4'hF, rd, e);
        c1 = rd;
        chk("cyc_err", {31'b0, e}, 32'd1);
        chk("cyc_rdata", c1, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
